avmm_sqrt_host: RTL and testbench

Avalon-MM host (initiator) that drives the square-root CSR agent: word 0 = radical (write), word 1 = Q (read), word 2 = remainder (read).
- Accepts an 8-bit radical on a valid/ready request port.
- Writes it to the radical CSR, waits for the sqrt IP to settle, reads Q and remainder.
- Returns both results on a valid/ready response port.
- Sits between a test sequencer or soft-logic client and the sqrt CSR agent, replacing CPU-driven register access.

---
 rtl/avmm_sqrt_pkg.sv | 29 ++
 rtl/avmm_sqrt_host_if.sv | 34 +++
 rtl/avmm_sqrt_rd_xfer.sv | 43 ++++
 rtl/avmm_sqrt_host.sv | 151 +++++++++++++++
 tb/tb_avmm_sqrt_host.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avmm_sqrt_pkg.sv
// rtl/avmm_sqrt_pkg.sv - shared CSR map, field widths and FSM states for the sqrt host
// Purpose: constants and types used by the sqrt CSR host, its read helper and its bus interface.
// Ports: none (package).
package avmm_sqrt_pkg;

    localparam int DATA_W = 32;

    // CSR word addresses of the sqrt agent
    localparam logic [1:0] RADICAL   = 2'd0;
    localparam logic [1:0] Q         = 2'd1;
    localparam logic [1:0] REMAINDER = 2'd2;

    // Meaningful field widths inside the 32-bit CSR words
    localparam int RADICAL_W = 8;
    localparam int Q_W       = 4;
    localparam int REM_W     = 5;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        SETTLE,
        RDQ,
        LATQ,
        RDR,
        LATR,
        RSP
    } state_t;

endpackage

// File: rtl/avmm_sqrt_host_if.sv
// rtl/avmm_sqrt_host_if.sv - Avalon-MM bus bundle between the sqrt host and the CSR agent
// Purpose: groups the Avalon-MM signals so the host takes a single bus port.
// Ports (signals): avm_address[1:0], avm_read, avm_write, avm_writedata[31:0] (host -> agent);
//                  avm_readdata[31:0], avm_waitrequest (agent -> host).
// Modports: master (host side), slave (agent side).
interface avmm_sqrt_host_if;
    import avmm_sqrt_pkg::*;

    logic [1:0]        avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        output avm_write,
        output avm_writedata,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        input  avm_write,
        input  avm_writedata,
        output avm_readdata,
        output avm_waitrequest
    );

endinterface

// File: rtl/avmm_sqrt_rd_xfer.sv
// rtl/avmm_sqrt_rd_xfer.sv - single Avalon-MM read with waitrequest and fixed read latency
// Purpose: issues the read strobe while rd_req is high, reports acceptance, and produces a
//          one-cycle data_valid pulse when readdata is to be sampled.
// Ports: clk, areset (sync, active-high); rd_req (hold high until accepted);
//        waitrequest, readdata (from agent); read (strobe to agent);
//        accepted (read taken this cycle); data_valid (sample data now); data (read word).
module avmm_sqrt_rd_xfer
    import avmm_sqrt_pkg::*;
#(
    parameter int READ_LATENCY = 0
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              rd_req,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata,
    output logic              read,
    output logic              accepted,
    output logic              data_valid,
    output logic [DATA_W-1:0] data
);

    logic [1:0] lat_cnt;

    assign read     = rd_req;
    assign accepted = rd_req & ~waitrequest;
    assign data     = readdata;

    // With zero latency data arrives in the accept cycle; otherwise the counter is loaded
    // on acceptance and the data cycle is the one where it holds 1.
    assign data_valid = (READ_LATENCY == 0) ? accepted : (lat_cnt == 2'd1);

    always_ff @(posedge clk) begin
        if (areset) begin
            lat_cnt <= 2'd0;
        end else if (accepted && (READ_LATENCY != 0)) begin
            lat_cnt <= 2'(READ_LATENCY);
        end else if (lat_cnt != 2'd0) begin
            lat_cnt <= lat_cnt - 2'd1;
        end
    end

endmodule

// File: rtl/avmm_sqrt_host.sv
// rtl/avmm_sqrt_host.sv - Avalon-MM host that runs one radical through the sqrt CSR agent
// Purpose: takes a radical on a valid/ready request, writes it to CSR 0, waits SETTLE_CYCLES,
//          reads Q (CSR 1) and remainder (CSR 2), and returns them on a valid/ready response.
// Ports: clk, areset (sync, active-high);
//        req_valid/req_ready/req_radical[7:0] (request);
//        rsp_valid/rsp_ready/rsp_q[3:0]/rsp_rem[4:0]/rsp_err (response);
//        avm (Avalon-MM master bus); busy (any state other than IDLE).
module avmm_sqrt_host
    import avmm_sqrt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int READ_LATENCY  = 0
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [RADICAL_W-1:0] req_radical,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [Q_W-1:0]       rsp_q,
    output logic [REM_W-1:0]     rsp_rem,
    output logic                 rsp_err,
    avmm_sqrt_host_if.master     avm,
    output logic                 busy
);

    state_t              state, state_n;
    logic [RADICAL_W-1:0] radical;
    logic [7:0]           settle_cnt;
    logic                 rd_req;
    logic                 rd_accepted;
    logic                 rd_dv;
    logic [DATA_W-1:0]    rd_data;

    avmm_sqrt_rd_xfer #(
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_xfer (
        .clk        (clk),
        .areset     (areset),
        .rd_req     (rd_req),
        .waitrequest(avm.avm_waitrequest),
        .readdata   (avm.avm_readdata),
        .read       (avm.avm_read),
        .accepted   (rd_accepted),
        .data_valid (rd_dv),
        .data       (rd_data)
    );

    always_ff @(posedge clk) begin
        if (areset) begin
            state      <= IDLE;
            radical    <= '0;
            settle_cnt <= '0;
            rsp_q      <= '0;
            rsp_rem    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && req_valid) begin
                radical <= req_radical;
            end
            if (state == WR && !avm.avm_waitrequest) begin
                settle_cnt <= 8'(SETTLE_CYCLES);
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt - 8'd1;
            end
            // Q read starts a fresh error flag; the remainder read can only add to it.
            if ((state == RDQ || state == LATQ) && rd_dv) begin
                rsp_q   <= rd_data[Q_W-1:0];
                rsp_err <= |rd_data[DATA_W-1:Q_W];
            end
            if ((state == RDR || state == LATR) && rd_dv) begin
                rsp_rem <= rd_data[REM_W-1:0];
                rsp_err <= rsp_err | (|rd_data[DATA_W-1:REM_W]);
            end
        end
    end

    always_comb begin
        state_n           = state;
        req_ready         = 1'b0;
        rsp_valid         = 1'b0;
        busy              = 1'b1;
        rd_req            = 1'b0;
        avm.avm_write     = 1'b0;
        avm.avm_address   = RADICAL;
        avm.avm_writedata = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_n = WR;
                end
            end
            WR: begin
                avm.avm_write     = 1'b1;
                avm.avm_address   = RADICAL;
                avm.avm_writedata = {{(DATA_W-RADICAL_W){1'b0}}, radical};
                if (!avm.avm_waitrequest) begin
                    state_n = (SETTLE_CYCLES == 0) ? RDQ : SETTLE;
                end
            end
            SETTLE: begin
                // Leave on the cycle whose decrement takes the counter to zero.
                if (settle_cnt <= 8'd1) begin
                    state_n = RDQ;
                end
            end
            RDQ: begin
                rd_req          = 1'b1;
                avm.avm_address = Q;
                if (rd_dv) begin
                    state_n = RDR;
                end else if (rd_accepted) begin
                    state_n = LATQ;
                end
            end
            LATQ: begin
                if (rd_dv) begin
                    state_n = RDR;
                end
            end
            RDR: begin
                rd_req          = 1'b1;
                avm.avm_address = REMAINDER;
                if (rd_dv) begin
                    state_n = RSP;
                end else if (rd_accepted) begin
                    state_n = LATR;
                end
            end
            LATR: begin
                if (rd_dv) begin
                    state_n = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_avmm_sqrt_host.sv
// tb/tb_avmm_sqrt_host.sv - self-checking bench for the sqrt CSR host
module tb_avmm_sqrt_host;

    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_radical = 8'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_q;
    logic [4:0] rsp_rem;
    logic       rsp_err;
    logic       busy;

    avmm_sqrt_host_if bus();

    avmm_sqrt_host #(
        .SETTLE_CYCLES(2),
        .READ_LATENCY (0)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_radical(req_radical),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_q      (rsp_q),
        .rsp_rem    (rsp_rem),
        .rsp_err    (rsp_err),
        .avm        (bus),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: table of floor(sqrt) and remainder built from square intervals.
    int model_q[256];
    int model_rem[256];

    // ---------------- behavioural CSR agent ----------------
    logic        agent_wait = 1'b0;
    logic [31:0] agent_rdata = 32'hFFFF_FFFF;
    logic [7:0]  agent_rad = 8'd0;
    int          stall_n = 0;
    int          stall_left = 0;
    bit          mid = 1'b0;
    logic [35:0] snap = '0;
    int          n_wr = 0;
    int          n_rd = 0;
    int          unstable = 0;
    int          bus_viol = 0;
    bit          q_ovr = 1'b0;
    logic [31:0] q_ovr_val = 32'h0;
    bit          r_ovr = 1'b0;
    logic [31:0] r_ovr_val = 32'h0;
    int          log_kind[$];
    int          log_addr[$];
    logic [31:0] log_data[$];

    assign bus.avm_waitrequest = agent_wait;
    assign bus.avm_readdata    = agent_rdata;

    function automatic int agent_sqrt(input logic [7:0] r);
        int q;
        q = 15;
        while (q * q > int'(r)) q--;
        return q;
    endfunction

    always @(negedge clk) begin : agent
        logic [35:0] cur;
        int          aq;
        cur = {bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata};
        if (bus.avm_read && bus.avm_write) bus_viol++;
        if (!bus.avm_write && bus.avm_writedata != 32'h0) bus_viol++;
        if (areset || !(bus.avm_read || bus.avm_write)) begin
            mid = 1'b0;
            agent_wait = 1'b0;
            agent_rdata = 32'hFFFF_FFFF;
        end else begin
            if (!mid) begin
                mid = 1'b1;
                snap = cur;
                stall_left = stall_n;
            end else if (cur !== snap) begin
                unstable++;
            end
            if (stall_left > 0) begin
                stall_left--;
                agent_wait = 1'b1;
                agent_rdata = 32'hFFFF_FFFF;
            end else begin
                agent_wait = 1'b0;
                mid = 1'b0;
                log_kind.push_back(bus.avm_write ? 1 : 0);
                log_addr.push_back(int'(bus.avm_address));
                log_data.push_back(bus.avm_writedata);
                if (bus.avm_write) begin
                    n_wr++;
                    if (bus.avm_address == 2'd0) agent_rad = bus.avm_writedata[7:0];
                    agent_rdata = 32'hFFFF_FFFF;
                end else begin
                    n_rd++;
                    aq = agent_sqrt(agent_rad);
                    if (bus.avm_address == 2'd1)
                        agent_rdata = q_ovr ? q_ovr_val : 32'(aq);
                    else if (bus.avm_address == 2'd2)
                        agent_rdata = r_ovr ? r_ovr_val : 32'(int'(agent_rad) - aq * aq);
                    else
                        agent_rdata = 32'h0;
                end
            end
        end
    end

    // ---------------- stimulus helpers (drive only) ----------------
    task automatic send_req(input logic [7:0] r);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_radical = r;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Called one cycle after acceptance; lat counts cycles from acceptance to rsp_valid.
    task automatic wait_rsp(output int lat, output bit rr_seen);
        lat = 1;
        rr_seen = 1'b0;
        while (!rsp_valid && lat < 400) begin
            if (req_ready) rr_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (req_ready) rr_seen = 1'b1;
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.avm_read, bus.avm_write, bus.avm_address} !== 4'b0 || bus.avm_writedata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got rd=%b wr=%b addr=%0d wd=%h required all 0",
                     bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata);
        end
        n_cmp++;
        if ({rsp_valid, rsp_q, rsp_rem, rsp_err, busy} !== 12'b0) begin
            n_bad++;
            $display("FAIL reset_rsp: got v=%b q=%0d rem=%0d err=%b busy=%b required all 0",
                     rsp_valid, rsp_q, rsp_rem, rsp_err, busy);
        end
        areset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_req_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        bit rr;
        stall_n = 0;
        log_kind.delete(); log_addr.delete(); log_data.delete();
        send_req(8'd200);
        wait_rsp(lat, rr);
        n_cmp++;
        if (lat != 6) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d required 6", lat);
        end
        n_cmp++;
        if ({rsp_q, rsp_rem, rsp_err} !== {4'd14, 5'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL basic_result: got q=%0d rem=%0d err=%b required 14 4 0", rsp_q, rsp_rem, rsp_err);
        end
        #2;
        n_cmp++;
        if (log_kind.size() != 3) begin
            n_bad++;
            $display("FAIL basic_bus_count: got %0d transfers required 3", log_kind.size());
        end else if (log_kind[0] != 1 || log_addr[0] != 0 || log_data[0] !== 32'h0000_00C8 ||
                     log_kind[1] != 0 || log_addr[1] != 1 || log_kind[2] != 0 || log_addr[2] != 2) begin
            n_bad++;
            $display("FAIL basic_bus_order: got k/a %0d/%0d(%h) %0d/%0d %0d/%0d required 1/0(000000c8) 0/1 0/2",
                     log_kind[0], log_addr[0], log_data[0], log_kind[1], log_addr[1], log_kind[2], log_addr[2]);
        end
        ack_rsp();
    endtask

    task automatic test_back_to_back();
        int lat;
        bit rr;
        stall_n = 0;
        send_req(8'd255);
        wait_rsp(lat, rr);
        n_cmp++;
        if ({rsp_q, rsp_rem, rsp_err} !== {4'd15, 5'd30, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_first: got q=%0d rem=%0d err=%b required 15 30 0", rsp_q, rsp_rem, rsp_err);
        end
        n_cmp++;
        if (rr !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_ready_low: got req_ready high while busy, required low");
        end
        // New request rises in the same cycle the response is taken.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_radical = 8'd0;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++;
        if ({req_ready, busy, rsp_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL b2b_idle_gap: got ready=%b busy=%b rsp_valid=%b required 1 0 0", req_ready, busy, rsp_valid);
        end
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if ({req_ready, busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL b2b_accept: got ready=%b busy=%b required 0 1", req_ready, busy);
        end
        wait_rsp(lat, rr);
        n_cmp++;
        if (lat != 6 || {rsp_q, rsp_rem, rsp_err} !== 10'b0) begin
            n_bad++;
            $display("FAIL b2b_second: got lat=%0d q=%0d rem=%0d err=%b required 6 0 0 0", lat, rsp_q, rsp_rem, rsp_err);
        end
        ack_rsp();
    endtask

    task automatic test_stall();
        int lat;
        bit rr;
        stall_n = 3;
        n_wr = 0; n_rd = 0; unstable = 0;
        send_req(8'd144);
        wait_rsp(lat, rr);
        n_cmp++;
        if (lat != 15 || {rsp_q, rsp_rem, rsp_err} !== {4'd12, 5'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL stall_result: got lat=%0d q=%0d rem=%0d err=%b required 15 12 0 0", lat, rsp_q, rsp_rem, rsp_err);
        end
        #2;
        n_cmp++;
        if (n_wr != 1 || n_rd != 2 || unstable != 0) begin
            n_bad++;
            $display("FAIL stall_bus: got writes=%0d reads=%0d unstable=%0d required 1 2 0", n_wr, n_rd, unstable);
        end
        stall_n = 0;
        ack_rsp();
    endtask

    task automatic test_hold();
        int lat;
        bit rr;
        int wr0, rd0;
        send_req(8'd50);
        wait_rsp(lat, rr);
        req_valid = 1'b1;
        req_radical = 8'd10;
        #2;
        wr0 = n_wr;
        rd0 = n_rd;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, rsp_q, rsp_rem, req_ready} !== {1'b1, 4'd7, 5'd1, 1'b0}) begin
                n_bad++;
                $display("FAIL hold_stable[%0d]: got v=%b q=%0d rem=%0d ready=%b required 1 7 1 0",
                         i, rsp_valid, rsp_q, rsp_rem, req_ready);
            end
        end
        #2;
        n_cmp++;
        if (n_wr != wr0 || n_rd != rd0) begin
            n_bad++;
            $display("FAIL hold_no_bus: got writes+%0d reads+%0d required 0 0", n_wr - wr0, n_rd - rd0);
        end
        @(negedge clk);
        ack_rsp();
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(lat, rr);
        n_cmp++;
        if (lat != 6 || {rsp_q, rsp_rem, rsp_err} !== {4'd3, 5'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL hold_next: got lat=%0d q=%0d rem=%0d err=%b required 6 3 1 0", lat, rsp_q, rsp_rem, rsp_err);
        end
        ack_rsp();
    endtask

    task automatic test_err();
        int lat;
        bit rr;
        q_ovr = 1'b1;
        q_ovr_val = 32'h0000_0103;
        send_req(8'd9);
        wait_rsp(lat, rr);
        n_cmp++;
        if ({rsp_q, rsp_rem, rsp_err} !== {4'd3, 5'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL err_q: got q=%0d rem=%0d err=%b required 3 0 1", rsp_q, rsp_rem, rsp_err);
        end
        ack_rsp();
        q_ovr = 1'b0;
        r_ovr = 1'b1;
        r_ovr_val = 32'h0000_0025;
        send_req(8'd9);
        wait_rsp(lat, rr);
        n_cmp++;
        if ({rsp_q, rsp_rem, rsp_err} !== {4'd3, 5'd5, 1'b1}) begin
            n_bad++;
            $display("FAIL err_rem: got q=%0d rem=%0d err=%b required 3 5 1", rsp_q, rsp_rem, rsp_err);
        end
        ack_rsp();
        r_ovr = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit rr;
        int n;
        send_req(8'd77);
        n = 0;
        while (!(bus.avm_read && bus.avm_address == 2'd1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.avm_read, bus.avm_write, busy, rsp_valid} !== 4'b0) begin
            n_bad++;
            $display("FAIL mid_reset: got rd=%b wr=%b busy=%b rsp_valid=%b required 0 0 0 0",
                     bus.avm_read, bus.avm_write, busy, rsp_valid);
        end
        areset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_ready: got %b required 1", req_ready);
        end
        send_req(8'd81);
        wait_rsp(lat, rr);
        n_cmp++;
        if (lat != 6 || {rsp_q, rsp_rem, rsp_err} !== {4'd9, 5'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_reset_after: got lat=%0d q=%0d rem=%0d err=%b required 6 9 0 0", lat, rsp_q, rsp_rem, rsp_err);
        end
        ack_rsp();
    endtask

    task automatic test_random();
        int lat;
        bit rr;
        int r, s, h;
        for (int k = 0; k < 24; k++) begin
            r = int'($urandom_range(0, 255));
            s = int'($urandom_range(0, 2));
            h = int'($urandom_range(0, 2));
            stall_n = s;
            send_req(8'(r));
            wait_rsp(lat, rr);
            n_cmp++;
            if (lat != 6 + 3 * s || int'(rsp_q) != model_q[r] || int'(rsp_rem) != model_rem[r] || rsp_err !== 1'b0) begin
                n_bad++;
                $display("FAIL random[%0d] r=%0d stall=%0d: got lat=%0d q=%0d rem=%0d err=%b required %0d %0d %0d 0",
                         k, r, s, lat, rsp_q, rsp_rem, rsp_err, 6 + 3 * s, model_q[r], model_rem[r]);
            end
            repeat (h) @(negedge clk);
            ack_rsp();
        end
        stall_n = 0;
    endtask

    initial begin
        for (int q = 0; q < 16; q++) begin
            for (int r = q * q; r < (q + 1) * (q + 1) && r < 256; r++) begin
                model_q[r] = q;
                model_rem[r] = r - q * q;
            end
        end
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_hold();
        test_err();
        test_reset_mid();
        test_random();
        #2;
        n_cmp++;
        if (bus_viol != 0) begin
            n_bad++;
            $display("FAIL bus_rules: got %0d violations required 0", bus_viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
